// File: rtl/oflow_apb_master_pkg.sv
// Shared types and widths for the APB initiator.
package oflow_apb_master_pkg;

    // Matches the oflow_reg_file address length.
    localparam int APB_ADDR_W = 8;
    localparam int APB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

endpackage

// File: rtl/oflow_apb_master_if.sv
// Command, response and APB signals of the initiator, bundled as one port.
interface oflow_apb_master_if
    import oflow_apb_master_pkg::*;
#(
    parameter int ADDR_W = APB_ADDR_W,
    parameter int DATA_W = APB_DATA_W
) ();

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_timeout;

    logic              apb_psel;
    logic              apb_penable;
    logic              apb_pwrite;
    logic [ADDR_W-1:0] apb_addr;
    logic [DATA_W-1:0] apb_pwdata;
    logic              apb_pready;
    logic [DATA_W-1:0] apb_prdata;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
        input  apb_pready, apb_prdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_timeout,
        output apb_psel, apb_penable, apb_pwrite, apb_addr, apb_pwdata
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
        output apb_pready, apb_prdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_timeout,
        input  apb_psel, apb_penable, apb_pwrite, apb_addr, apb_pwdata
    );

endinterface

// File: rtl/oflow_apb_timeout_cnt.sv
// Cycle counter with clear, enable and a programmable limit.
// hit_o fires on the enabled cycle whose increment would reach limit_i;
// a zero limit never fires.
module oflow_apb_timeout_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] limit_i,
    output logic             hit_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next count: clear wins, otherwise count enabled cycles without wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i && (cnt_q != '1))
            cnt_d = cnt_q + 1'b1;
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign hit_o = en_i && (limit_i != '0) && (cnt_q >= limit_i - 1'b1);

endmodule

// File: rtl/oflow_apb_master.sv
// APB initiator: one command in, one SETUP/ACCESS transfer out, one response
// back. ACCESS is aborted after TIMEOUT_CYCLES stalled cycles (0 = never).
module oflow_apb_master
    import oflow_apb_master_pkg::*;
#(
    parameter int ADDR_W         = APB_ADDR_W,
    parameter int DATA_W         = APB_DATA_W,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 16
) (
    input  logic               clk,
    input  logic               reset,
    oflow_apb_master_if.master bus,
    output logic               busy,
    output logic [CNT_W-1:0]   txn_count,
    output logic [CNT_W-1:0]   timeout_count
);

    apb_state_e state_q, state_d;

    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rsp_tmo_q, rsp_tmo_d;
    logic              busy_q, busy_d;
    logic [CNT_W-1:0]  txn_q, txn_d;
    logic [CNT_W-1:0]  tocnt_q, tocnt_d;

    logic req_ready_w;
    logic accept;
    logic stall;
    logic tmo_hit;
    logic xfer_done;
    logic xfer_tmo;

    // Only combinational output: forced low while reset is high.
    assign req_ready_w = (state_q == IDLE) && !reset;
    assign accept      = bus.req_valid && req_ready_w;
    assign stall       = (state_q == ACCESS) && !bus.apb_pready;
    // pready in the limit cycle takes priority over the abort.
    assign xfer_done   = (state_q == ACCESS) && bus.apb_pready;
    assign xfer_tmo    = stall && tmo_hit;

    oflow_apb_timeout_cnt #(
        .CNT_W (CNT_W)
    ) u_tmo_cnt (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (accept),
        .en_i    (stall),
        .limit_i (CNT_W'(TIMEOUT_CYCLES)),
        .hit_o   (tmo_hit)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (xfer_done || xfer_tmo) state_d = RESP;
            RESP:    if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output next-values; everything holds unless the current state changes it.
    always_comb begin
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        addr_d      = addr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = rsp_valid_q;
        rdata_d     = rdata_q;
        rsp_tmo_d   = rsp_tmo_q;
        txn_d       = txn_q;
        tocnt_d     = tocnt_q;
        busy_d      = (state_d != IDLE);
        case (state_q)
            IDLE: begin
                if (accept) begin
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    pwrite_d  = bus.req_write;
                    addr_d    = bus.req_addr;
                    pwdata_d  = bus.req_wdata;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
            end
            ACCESS: begin
                if (xfer_done) begin
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rdata_d     = pwrite_q ? '0 : bus.apb_prdata;
                    rsp_tmo_d   = 1'b0;
                    txn_d       = txn_q + 1'b1;
                end else if (xfer_tmo) begin
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rdata_d     = '0;
                    rsp_tmo_d   = 1'b1;
                    tocnt_d     = (tocnt_q == '1) ? tocnt_q : tocnt_q + 1'b1;
                end
            end
            RESP: begin
                if (bus.rsp_ready)
                    rsp_valid_d = 1'b0;
            end
            default: ;
        endcase
    end

    // Output registers; reset abandons any transfer without a response.
    always_ff @(posedge clk) begin
        if (reset) begin
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            addr_q      <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            rsp_tmo_q   <= 1'b0;
            busy_q      <= 1'b0;
            txn_q       <= '0;
            tocnt_q     <= '0;
        end else begin
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            addr_q      <= addr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            rsp_tmo_q   <= rsp_tmo_d;
            busy_q      <= busy_d;
            txn_q       <= txn_d;
            tocnt_q     <= tocnt_d;
        end
    end

    assign bus.req_ready   = req_ready_w;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rdata_q;
    assign bus.rsp_timeout = rsp_tmo_q;
    assign bus.apb_psel    = psel_q;
    assign bus.apb_penable = penable_q;
    assign bus.apb_pwrite  = pwrite_q;
    assign bus.apb_addr    = addr_q;
    assign bus.apb_pwdata  = pwdata_q;

    assign busy          = busy_q;
    assign txn_count     = txn_q;
    assign timeout_count = tocnt_q;

endmodule

// File: tb/tb_oflow_apb_master.sv
// Directed bench: APB initiator against a small reg-file stub slave.
module tb_oflow_apb_master;
    import oflow_apb_master_pkg::*;

    localparam int AW = APB_ADDR_W;
    localparam int DW = APB_DATA_W;
    localparam int CW = 16;
    localparam logic [AW-1:0] NUM_OF_HISTORY_FRAMES_ADDR = 8'h04;
    localparam logic [AW-1:0] W_IOU_ADDR                 = 8'h08;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic busy;
    logic [CW-1:0] txn_count, timeout_count;

    always #5 clk = ~clk;

    oflow_apb_master_if bus ();

    oflow_apb_master #(
        .TIMEOUT_CYCLES (16),
        .CNT_W          (CW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus),
        .busy          (busy),
        .txn_count     (txn_count),
        .timeout_count (timeout_count)
    );

    // ---------------- stub reg-file slave ----------------
    logic        reset_N;
    logic [31:0] num_of_history_frame;
    logic [9:0]  w_iou;
    logic        stall_all = 1'b0;
    int          delay = 0;
    logic [7:0]  acc_cyc;

    assign reset_N        = ~reset;
    assign bus.apb_pready = !stall_all && (int'(acc_cyc) >= delay);
    assign bus.apb_prdata = (bus.apb_addr == NUM_OF_HISTORY_FRAMES_ADDR) ? num_of_history_frame :
                            (bus.apb_addr == W_IOU_ADDR) ? {22'b0, w_iou} : 32'h0;

    always @(posedge clk) begin
        if (!reset_N) begin
            num_of_history_frame <= 32'h0;
            w_iou                <= 10'h0;
            acc_cyc              <= 8'h0;
        end else begin
            if (bus.apb_psel && bus.apb_penable && !bus.apb_pready) acc_cyc <= acc_cyc + 8'h1;
            else acc_cyc <= 8'h0;
            if (bus.apb_psel && bus.apb_penable && bus.apb_pready && bus.apb_pwrite) begin
                if (bus.apb_addr == NUM_OF_HISTORY_FRAMES_ADDR) num_of_history_frame <= bus.apb_pwdata;
                if (bus.apb_addr == W_IOU_ADDR) w_iou <= bus.apb_pwdata[9:0];
            end
        end
    end

    // ---------------- cycle count + protocol monitor ----------------
    int cyc = 0;
    int pass_cnt = 0, tot_cnt = 0, mon_pass = 0, mon_tot = 0;
    int setup_q[$];
    logic prev_psel = 1'b0;
    logic [AW-1:0] prev_addr = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // ACCESS must follow a selected cycle with the same address.
    always @(negedge clk) begin
        if (bus.apb_psel && !bus.apb_penable) setup_q.push_back(cyc);
        if (bus.apb_penable) begin
            mon_tot <= mon_tot + 1;
            if (bus.apb_psel && prev_psel && bus.apb_addr == prev_addr) mon_pass <= mon_pass + 1;
            else $display("FAIL apb_protocol: cycle %0d psel=%0b prev_psel=%0b addr=%0h prev_addr=%0h",
                          cyc, bus.apb_psel, prev_psel, bus.apb_addr, prev_addr);
        end
        prev_psel <= bus.apb_psel;
        prev_addr <= bus.apb_addr;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one command; n = cycle in which it was accepted.
    task automatic send(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d, output int n);
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_wdata = d;
        n = -1;
        for (int i = 0; i < 40 && n < 0; i++) begin
            if (bus.req_ready === 1'b1) n = cyc;
            tick();
        end
        bus.req_valid = 1'b0;
        if (n < 0) begin
            tot_cnt++;
            $display("FAIL send_accept: req_ready never seen within 40 cycles");
        end
    endtask

    // Waits for rsp_valid; m = its cycle, acc = ACCESS cycles, rr = cycles with req_ready.
    task automatic wait_rsp(output int m, output int acc, output int rr);
        m = -1; acc = 0; rr = 0;
        for (int i = 0; i < 60 && m < 0; i++) begin
            if (bus.apb_psel && bus.apb_penable) acc++;
            if (bus.req_ready) rr++;
            if (bus.rsp_valid === 1'b1) m = cyc;
            else tick();
        end
        if (m < 0) begin
            tot_cnt++;
            $display("FAIL wait_rsp: rsp_valid never seen within 60 cycles");
        end
    endtask

    task automatic consume();
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        tot_cnt++; if (bus.req_ready !== 1'b0) $display("FAIL rst_req_ready: got %0b want 0", bus.req_ready); else pass_cnt++;
        tot_cnt++; if (bus.apb_psel !== 1'b0 || bus.apb_penable !== 1'b0) $display("FAIL rst_psel: got %0b%0b want 00", bus.apb_psel, bus.apb_penable); else pass_cnt++;
        tot_cnt++; if (bus.rsp_valid !== 1'b0) $display("FAIL rst_rsp_valid: got %0b want 0", bus.rsp_valid); else pass_cnt++;
        tot_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy: got %0b want 0", busy); else pass_cnt++;
        tot_cnt++; if (txn_count !== 16'd0 || timeout_count !== 16'd0) $display("FAIL rst_counts: got %0d/%0d want 0/0", txn_count, timeout_count); else pass_cnt++;
        reset = 1'b0;
        #1;
        tot_cnt++; if (bus.req_ready !== 1'b1) $display("FAIL rst_release_ready: got %0b want 1", bus.req_ready); else pass_cnt++;
    endtask

    task automatic test_write_hist();
        int n, m, acc, rr;
        send(1'b1, NUM_OF_HISTORY_FRAMES_ADDR, 32'h5, n);
        tot_cnt++; if (busy !== 1'b1) $display("FAIL hist_busy: got %0b want 1", busy); else pass_cnt++;
        wait_rsp(m, acc, rr);
        tot_cnt++; if (m != n + 3) $display("FAIL hist_latency: got %0d want %0d", m - n, 3); else pass_cnt++;
        tot_cnt++; if (bus.rsp_timeout !== 1'b0) $display("FAIL hist_timeout: got %0b want 0", bus.rsp_timeout); else pass_cnt++;
        tot_cnt++; if (bus.rsp_rdata !== 32'h0) $display("FAIL hist_wr_rdata: got %0h want 0", bus.rsp_rdata); else pass_cnt++;
        tot_cnt++; if (acc != 1) $display("FAIL hist_access_len: got %0d want 1", acc); else pass_cnt++;
        consume();
        tot_cnt++; if (num_of_history_frame !== 32'h5) $display("FAIL hist_reg: got %0h want 5", num_of_history_frame); else pass_cnt++;
        tot_cnt++; if (txn_count !== 16'd1) $display("FAIL hist_txn: got %0d want 1", txn_count); else pass_cnt++;
    endtask

    task automatic test_iou_rw();
        int n, m, acc, rr;
        send(1'b1, W_IOU_ADDR, 32'h100, n);
        wait_rsp(m, acc, rr);
        consume();
        tot_cnt++; if (w_iou !== 10'h100) $display("FAIL iou_reg: got %0h want 100", w_iou); else pass_cnt++;
        send(1'b0, W_IOU_ADDR, 32'hDEAD_BEEF, n);
        wait_rsp(m, acc, rr);
        tot_cnt++; if (bus.rsp_rdata[9:0] !== 10'h100) $display("FAIL iou_rdata: got %0h want 100", bus.rsp_rdata[9:0]); else pass_cnt++;
        tot_cnt++; if (bus.rsp_rdata !== 32'h100) $display("FAIL iou_rdata_full: got %0h want 100", bus.rsp_rdata); else pass_cnt++;
        consume();
        tot_cnt++; if (txn_count !== 16'd3) $display("FAIL iou_txn: got %0d want 3", txn_count); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int n1, n2, m, acc, rr;
        setup_q.delete();
        bus.rsp_ready = 1'b1;
        send(1'b1, W_IOU_ADDR, 32'h180, n1);
        send(1'b0, NUM_OF_HISTORY_FRAMES_ADDR, 32'h0, n2);
        wait_rsp(m, acc, rr);
        tot_cnt++; if (bus.rsp_rdata !== 32'h5) $display("FAIL b2b_rdata: got %0h want 5", bus.rsp_rdata); else pass_cnt++;
        tick();
        bus.rsp_ready = 1'b0;
        tot_cnt++; if (setup_q.size() != 2) $display("FAIL b2b_setups: got %0d want 2", setup_q.size()); else pass_cnt++;
        tot_cnt++;
        if (setup_q.size() == 2 && setup_q[1] - setup_q[0] == 4) pass_cnt++;
        else $display("FAIL b2b_spacing: got %0d want 4", (setup_q.size() == 2) ? setup_q[1] - setup_q[0] : -1);
        tot_cnt++; if (w_iou !== 10'h180) $display("FAIL b2b_iou: got %0h want 180", w_iou); else pass_cnt++;
        tot_cnt++; if (txn_count !== 16'd5) $display("FAIL b2b_txn: got %0d want 5", txn_count); else pass_cnt++;
    endtask

    task automatic test_timeout();
        int n, m, acc, rr;
        stall_all = 1'b1;
        send(1'b0, W_IOU_ADDR, 32'h0, n);
        wait_rsp(m, acc, rr);
        tot_cnt++; if (acc != 16) $display("FAIL tmo_access_len: got %0d want 16", acc); else pass_cnt++;
        tot_cnt++; if (m != n + 18) $display("FAIL tmo_latency: got %0d want 18", m - n); else pass_cnt++;
        tot_cnt++; if (bus.apb_psel !== 1'b0) $display("FAIL tmo_psel: got %0b want 0", bus.apb_psel); else pass_cnt++;
        tot_cnt++; if (bus.rsp_timeout !== 1'b1) $display("FAIL tmo_flag: got %0b want 1", bus.rsp_timeout); else pass_cnt++;
        tot_cnt++; if (bus.rsp_rdata !== 32'h0) $display("FAIL tmo_rdata: got %0h want 0", bus.rsp_rdata); else pass_cnt++;
        tot_cnt++; if (timeout_count !== 16'd1) $display("FAIL tmo_count: got %0d want 1", timeout_count); else pass_cnt++;
        tot_cnt++; if (txn_count !== 16'd5) $display("FAIL tmo_txn: got %0d want 5", txn_count); else pass_cnt++;
        consume();
        stall_all = 1'b0;
    endtask

    // pready arrives in the 16th ACCESS cycle, the same cycle as the limit.
    task automatic test_limit_completion();
        int n, m, acc, rr;
        delay = 15;
        send(1'b0, NUM_OF_HISTORY_FRAMES_ADDR, 32'h0, n);
        wait_rsp(m, acc, rr);
        tot_cnt++; if (acc != 16) $display("FAIL lim_access_len: got %0d want 16", acc); else pass_cnt++;
        tot_cnt++; if (bus.rsp_timeout !== 1'b0) $display("FAIL lim_flag: got %0b want 0", bus.rsp_timeout); else pass_cnt++;
        tot_cnt++; if (bus.rsp_rdata !== 32'h5) $display("FAIL lim_rdata: got %0h want 5", bus.rsp_rdata); else pass_cnt++;
        tot_cnt++; if (timeout_count !== 16'd1 || txn_count !== 16'd6) $display("FAIL lim_counts: got %0d/%0d want 1/6", timeout_count, txn_count); else pass_cnt++;
        consume();
        delay = 0;
    endtask

    task automatic test_stall();
        int n, m, acc, rr;
        delay = 3;
        send(1'b0, NUM_OF_HISTORY_FRAMES_ADDR, 32'h0, n);
        wait_rsp(m, acc, rr);
        tot_cnt++; if (acc != 4) $display("FAIL stall_access_len: got %0d want 4", acc); else pass_cnt++;
        tot_cnt++; if (rr != 0) $display("FAIL stall_req_ready: got %0d cycles want 0", rr); else pass_cnt++;
        for (int i = 0; i < 5; i++) begin
            tick();
            tot_cnt++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'h5 || bus.rsp_timeout !== 1'b0 || bus.req_ready !== 1'b0)
                $display("FAIL stall_hold%0d: got v=%0b d=%0h t=%0b rr=%0b want v=1 d=5 t=0 rr=0",
                         i, bus.rsp_valid, bus.rsp_rdata, bus.rsp_timeout, bus.req_ready);
            else pass_cnt++;
        end
        consume();
        tot_cnt++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) $display("FAIL stall_release: got v=%0b rr=%0b want 0/1", bus.rsp_valid, bus.req_ready); else pass_cnt++;
        tot_cnt++; if (txn_count !== 16'd7) $display("FAIL stall_txn: got %0d want 7", txn_count); else pass_cnt++;
        delay = 0;
    endtask

    task automatic test_reset_mid();
        int n;
        int seen;
        stall_all = 1'b1;
        send(1'b1, W_IOU_ADDR, 32'h3FF, n);
        tick();
        tot_cnt++; if (bus.apb_penable !== 1'b1) $display("FAIL mid_in_access: got %0b want 1", bus.apb_penable); else pass_cnt++;
        reset = 1'b1;
        tick();
        tot_cnt++; if (bus.apb_psel !== 1'b0 || bus.apb_penable !== 1'b0) $display("FAIL mid_psel: got %0b%0b want 00", bus.apb_psel, bus.apb_penable); else pass_cnt++;
        tot_cnt++; if (bus.req_ready !== 1'b0) $display("FAIL mid_req_ready_in_rst: got %0b want 0", bus.req_ready); else pass_cnt++;
        tot_cnt++; if (txn_count !== 16'd0 || busy !== 1'b0) $display("FAIL mid_state: got txn=%0d busy=%0b want 0/0", txn_count, busy); else pass_cnt++;
        reset = 1'b0;
        stall_all = 1'b0;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus.rsp_valid !== 1'b0) seen++;
            tick();
        end
        tot_cnt++; if (seen != 0) $display("FAIL mid_no_rsp: got %0d rsp_valid cycles want 0", seen); else pass_cnt++;
        tot_cnt++; if (bus.req_ready !== 1'b1) $display("FAIL mid_req_ready: got %0b want 1", bus.req_ready); else pass_cnt++;
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b0;
        test_reset();
        test_write_hist();
        test_iou_rw();
        test_back_to_back();
        test_timeout();
        test_limit_completion();
        test_stall();
        test_reset_mid();
        tick();
        $display("%0d/%0d checks passed", pass_cnt + mon_pass, tot_cnt + mon_tot);
        $finish;
    end

endmodule
